riscv_rsb: RTL and testbench

RISCV_RSB -- requirements
Module: riscv_rsb

---
 rtl/riscv_rsb.sv | 117 +++++++++++
 tb/tb_riscv_rsb.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_rsb.sv
// Return stack buffer: circular stack of return addresses with checkpoint/restore
// for mispredict recovery and saturating overflow/underflow statistics.
module riscv_rsb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 16,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNTW      = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [ADDR_WIDTH-1:0] push_addr_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  input  logic                  restore_i,
  input  logic [PTR_W-1:0]      restore_ptr_i,
  input  logic [CNTW-1:0]       restore_cnt_i,
  output logic                  pred_valid_o,
  output logic [ADDR_WIDTH-1:0] pred_addr_o,
  output logic [PTR_W-1:0]      ckpt_ptr_o,
  output logic [CNTW-1:0]       ckpt_cnt_o,
  output logic [CNT_WIDTH-1:0]  overflow_cnt_o,
  output logic [CNT_WIDTH-1:0]  underflow_cnt_o
);

  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  logic [ADDR_WIDTH-1:0] entry_r [DEPTH];
  logic [PTR_W-1:0]      tos_r;
  logic [CNTW-1:0]       cnt_r;
  logic [CNT_WIDTH-1:0]  ovf_r;
  logic [CNT_WIDTH-1:0]  unf_r;

  logic [PTR_W-1:0]      tos_n_s;
  logic [CNTW-1:0]       cnt_n_s;
  logic                  wr_en_s;
  logic [PTR_W-1:0]      wr_idx_s;
  logic                  ovf_inc_s;
  logic                  unf_inc_s;

  // Command decode: restore beats flush beats push/pop.
  always_comb begin
    tos_n_s   = tos_r;
    cnt_n_s   = cnt_r;
    wr_en_s   = 1'b0;
    wr_idx_s  = tos_r;
    ovf_inc_s = 1'b0;
    unf_inc_s = 1'b0;
    if (restore_i) begin
      tos_n_s = restore_ptr_i;
      cnt_n_s = (restore_cnt_i > FULL_CNT) ? FULL_CNT : restore_cnt_i;
    end else if (flush_i) begin
      cnt_n_s = {CNTW{1'b0}};
    end else if (push_i && pop_i && (cnt_r != {CNTW{1'b0}})) begin
      // Co-routine swap: replace the top in place.
      wr_en_s  = 1'b1;
      wr_idx_s = tos_r;
    end else if (push_i) begin
      wr_en_s  = 1'b1;
      wr_idx_s = tos_r + PTR_W'(1);
      tos_n_s  = tos_r + PTR_W'(1);
      if (cnt_r == FULL_CNT) begin
        ovf_inc_s = 1'b1;
      end else begin
        cnt_n_s = cnt_r + CNTW'(1);
      end
    end else if (pop_i) begin
      if (cnt_r != {CNTW{1'b0}}) begin
        tos_n_s = tos_r - PTR_W'(1);
        cnt_n_s = cnt_r - CNTW'(1);
      end else begin
        unf_inc_s = 1'b1;
      end
    end else begin
      tos_n_s = tos_r;
    end
  end

  // Pointer, occupancy and saturating statistics registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tos_r <= {PTR_W{1'b0}};
      cnt_r <= {CNTW{1'b0}};
      ovf_r <= {CNT_WIDTH{1'b0}};
      unf_r <= {CNT_WIDTH{1'b0}};
    end else begin
      tos_r <= tos_n_s;
      cnt_r <= cnt_n_s;
      if (ovf_inc_s && (ovf_r != {CNT_WIDTH{1'b1}})) begin
        ovf_r <= ovf_r + CNT_WIDTH'(1);
      end
      if (unf_inc_s && (unf_r != {CNT_WIDTH{1'b1}})) begin
        unf_r <= unf_r + CNT_WIDTH'(1);
      end
    end
  end

  // Return address storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= {ADDR_WIDTH{1'b0}};
      end
    end else if (wr_en_s) begin
      entry_r[wr_idx_s] <= push_addr_i;
    end
  end

  assign pred_valid_o    = (cnt_r != {CNTW{1'b0}});
  assign pred_addr_o     = entry_r[tos_r];
  assign ckpt_ptr_o      = tos_r;
  assign ckpt_cnt_o      = cnt_r;
  assign overflow_cnt_o  = ovf_r;
  assign underflow_cnt_o = unf_r;

endmodule

// File: tb/tb_riscv_rsb.sv
// Table-driven bench for riscv_rsb (DEPTH=4, CNT_WIDTH=3) with a queue scoreboard
// plus hand-written asynchronous reset sequences.
module tb_riscv_rsb;
  localparam int AW = 32;
  localparam int DEPTH = 4;
  localparam int CW = 3;
  localparam int PW = 2;
  localparam int NW = 3;

  typedef struct {
    logic          valid;
    logic [AW-1:0] addr;
    logic [PW-1:0] ptr;
    logic [NW-1:0] cnt;
    logic [CW-1:0] ovf;
    logic [CW-1:0] unf;
  } exp_t;

  typedef struct {
    logic          push;
    logic [AW-1:0] addr;
    logic          pop;
    logic          flush;
    logic          restore;
    logic [PW-1:0] rptr;
    logic [NW-1:0] rcnt;
    exp_t          e;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          push_i = 1'b0;
  logic [AW-1:0] push_addr_i = '0;
  logic          pop_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          restore_i = 1'b0;
  logic [PW-1:0] restore_ptr_i = '0;
  logic [NW-1:0] restore_cnt_i = '0;
  logic          pred_valid_o;
  logic [AW-1:0] pred_addr_o;
  logic [PW-1:0] ckpt_ptr_o;
  logic [NW-1:0] ckpt_cnt_o;
  logic [CW-1:0] overflow_cnt_o;
  logic [CW-1:0] underflow_cnt_o;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  vec_t vecs[$];

  riscv_rsb #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .push_i(push_i), .push_addr_i(push_addr_i),
    .pop_i(pop_i), .flush_i(flush_i), .restore_i(restore_i),
    .restore_ptr_i(restore_ptr_i), .restore_cnt_i(restore_cnt_i),
    .pred_valid_o(pred_valid_o), .pred_addr_o(pred_addr_o),
    .ckpt_ptr_o(ckpt_ptr_o), .ckpt_cnt_o(ckpt_cnt_o),
    .overflow_cnt_o(overflow_cnt_o), .underflow_cnt_o(underflow_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk_e(logic v, logic [AW-1:0] a, logic [PW-1:0] p,
                                logic [NW-1:0] c, logic [CW-1:0] o, logic [CW-1:0] u);
    exp_t e;
    e.valid = v; e.addr = a; e.ptr = p; e.cnt = c; e.ovf = o; e.unf = u;
    return e;
  endfunction

  function automatic vec_t mk_v(logic pu, logic [AW-1:0] a, logic po, logic fl, logic rs,
                                logic [PW-1:0] rp, logic [NW-1:0] rc, exp_t e);
    vec_t r;
    r.push = pu; r.addr = a; r.pop = po; r.flush = fl; r.restore = rs;
    r.rptr = rp; r.rcnt = rc; r.e = e;
    return r;
  endfunction

  task automatic chk(string name, int idx, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=0x%0h required=0x%0h", name, idx, act, exp);
    end
  endtask

  // Pops the oldest expectation and compares it against the current outputs.
  task automatic compare_top(int idx);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty step=%0d actual=0 required=1", idx);
      return;
    end
    e = exp_q.pop_front();
    chk("pred_valid", idx, 64'(pred_valid_o), 64'(e.valid));
    chk("pred_addr",  idx, 64'(pred_addr_o),  64'(e.addr));
    chk("ckpt_ptr",   idx, 64'(ckpt_ptr_o),   64'(e.ptr));
    chk("ckpt_cnt",   idx, 64'(ckpt_cnt_o),   64'(e.cnt));
    chk("overflow",   idx, 64'(overflow_cnt_o),  64'(e.ovf));
    chk("underflow",  idx, 64'(underflow_cnt_o), 64'(e.unf));
  endtask

  task automatic drive(vec_t v);
    push_i = v.push; push_addr_i = v.addr; pop_i = v.pop; flush_i = v.flush;
    restore_i = v.restore; restore_ptr_i = v.rptr; restore_cnt_i = v.rcnt;
  endtask

  task automatic idle();
    push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0; restore_i = 1'b0;
    push_addr_i = '0; restore_ptr_i = '0; restore_cnt_i = '0;
  endtask

  initial begin
    // push/addr/pop/flush/restore/rptr/rcnt -> valid/addr/ptr/cnt/ovf/unf after the edge
    vecs.push_back(mk_v(1, 32'h100, 0, 0, 0, 0, 0, mk_e(1, 32'h100, 1, 1, 0, 0)));
    vecs.push_back(mk_v(1, 32'h200, 0, 0, 0, 0, 0, mk_e(1, 32'h200, 2, 2, 0, 0)));
    vecs.push_back(mk_v(1, 32'h300, 0, 0, 0, 0, 0, mk_e(1, 32'h300, 3, 3, 0, 0)));
    vecs.push_back(mk_v(0, 0, 1, 0, 0, 0, 0, mk_e(1, 32'h200, 2, 2, 0, 0)));
    vecs.push_back(mk_v(0, 0, 1, 0, 0, 0, 0, mk_e(1, 32'h100, 1, 1, 0, 0)));
    vecs.push_back(mk_v(0, 0, 1, 0, 0, 0, 0, mk_e(0, 32'h0,   0, 0, 0, 0)));
    vecs.push_back(mk_v(0, 0, 1, 0, 0, 0, 0, mk_e(0, 32'h0,   0, 0, 0, 1)));
    vecs.push_back(mk_v(0, 0, 1, 0, 0, 0, 0, mk_e(0, 32'h0,   0, 0, 0, 2)));
    vecs.push_back(mk_v(1, 32'h10, 0, 0, 0, 0, 0, mk_e(1, 32'h10, 1, 1, 0, 2)));
    vecs.push_back(mk_v(1, 32'h20, 0, 0, 0, 0, 0, mk_e(1, 32'h20, 2, 2, 0, 2)));
    vecs.push_back(mk_v(1, 32'h30, 0, 0, 0, 0, 0, mk_e(1, 32'h30, 3, 3, 0, 2)));
    vecs.push_back(mk_v(1, 32'h40, 0, 0, 0, 0, 0, mk_e(1, 32'h40, 0, 4, 0, 2)));
    vecs.push_back(mk_v(1, 32'h50, 0, 0, 0, 0, 0, mk_e(1, 32'h50, 1, 4, 1, 2)));
    vecs.push_back(mk_v(0, 0, 1, 0, 0, 0, 0, mk_e(1, 32'h40, 0, 3, 1, 2)));
    vecs.push_back(mk_v(0, 0, 1, 0, 0, 0, 0, mk_e(1, 32'h30, 3, 2, 1, 2)));
    vecs.push_back(mk_v(0, 0, 1, 0, 0, 0, 0, mk_e(1, 32'h20, 2, 1, 1, 2)));
    vecs.push_back(mk_v(0, 0, 1, 0, 0, 0, 0, mk_e(0, 32'h50, 1, 0, 1, 2)));
    vecs.push_back(mk_v(1, 32'hA0, 0, 0, 0, 0, 0, mk_e(1, 32'hA0, 2, 1, 1, 2)));
    vecs.push_back(mk_v(1, 32'hB0, 1, 0, 0, 0, 0, mk_e(1, 32'hB0, 2, 1, 1, 2)));
    vecs.push_back(mk_v(0, 0, 0, 1, 0, 0, 0, mk_e(0, 32'hB0, 2, 0, 1, 2)));
    vecs.push_back(mk_v(1, 32'hC0, 1, 0, 0, 0, 0, mk_e(1, 32'hC0, 3, 1, 1, 2)));
    vecs.push_back(mk_v(0, 0, 0, 0, 1, 0, 0, mk_e(0, 32'h40, 0, 0, 1, 2)));
    vecs.push_back(mk_v(1, 32'h1, 0, 0, 0, 0, 0, mk_e(1, 32'h1, 1, 1, 1, 2)));
    vecs.push_back(mk_v(1, 32'h2, 0, 0, 0, 0, 0, mk_e(1, 32'h2, 2, 2, 1, 2)));
    vecs.push_back(mk_v(1, 32'h3, 0, 0, 0, 0, 0, mk_e(1, 32'h3, 3, 3, 1, 2)));
    vecs.push_back(mk_v(0, 0, 1, 0, 0, 0, 0, mk_e(1, 32'h2, 2, 2, 1, 2)));
    vecs.push_back(mk_v(0, 0, 1, 0, 0, 0, 0, mk_e(1, 32'h1, 1, 1, 1, 2)));
    vecs.push_back(mk_v(0, 0, 0, 0, 1, 2, 2, mk_e(1, 32'h2, 2, 2, 1, 2)));
    vecs.push_back(mk_v(1, 32'hDEAD, 1, 1, 1, 1, 1, mk_e(1, 32'h1, 1, 1, 1, 2)));
    vecs.push_back(mk_v(1, 32'hBEEF, 0, 1, 1, 3, 7, mk_e(1, 32'h3, 3, 4, 1, 2)));
    vecs.push_back(mk_v(1, 32'h77, 0, 1, 0, 0, 0, mk_e(0, 32'h3, 3, 0, 1, 2)));
    for (int k = 0; k < 6; k++) begin
      vecs.push_back(mk_v(0, 0, 1, 0, 0, 0, 0,
                          mk_e(0, 32'h3, 3, 0, 1, (k + 3 > 7) ? 3'd7 : CW'(k + 3))));
    end

    // Reset state, then release away from an edge.
    #2;
    exp_q.push_back(mk_e(0, 32'h0, 0, 0, 0, 0));
    compare_top(-1);
    @(negedge clk);
    rst_ni = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      exp_q.push_back(vecs[i].e);
      @(posedge clk);
      #1;
      compare_top(i);
    end

    // Asynchronous reset mid-cycle clears everything without a clock edge.
    @(negedge clk);
    idle();
    push_i = 1'b1; push_addr_i = 32'h44;
    exp_q.push_back(mk_e(1, 32'h44, 0, 1, 1, 7));
    @(posedge clk);
    #1;
    compare_top(100);
    push_addr_i = 32'h55;
    #2;
    rst_ni = 1'b0;
    #1;
    exp_q.push_back(mk_e(0, 32'h0, 0, 0, 0, 0));
    compare_top(101);
    // A push held through reset edges must not take effect.
    @(posedge clk);
    #1;
    exp_q.push_back(mk_e(0, 32'h0, 0, 0, 0, 0));
    compare_top(102);
    // First edge after release processes the pending push.
    @(negedge clk);
    rst_ni = 1'b1;
    exp_q.push_back(mk_e(1, 32'h55, 1, 1, 0, 0));
    @(posedge clk);
    #1;
    compare_top(103);
    @(negedge clk);
    idle();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
